// File: rtl/regpair_writer_pkg.sv
// Shared encodings for the register-pair write sequencer: ops, pairs, byte-index helpers, FSM states.
package regpair_writer_pkg;

   localparam logic [1:0] OP_LOAD = 2'd0;
   localparam logic [1:0] OP_INC  = 2'd1;
   localparam logic [1:0] OP_DEC  = 2'd2;
   localparam logic [1:0] OP_ADDS = 2'd3;

   localparam logic [1:0] PAIR_BC = 2'd0;
   localparam logic [1:0] PAIR_DE = 2'd1;
   localparam logic [1:0] PAIR_HL = 2'd2;
   localparam logic [1:0] PAIR_SP = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WR_LO = 2'd1,
      ST_WR_HI = 2'd2
   } state_e;

   // High byte of a pair sits at the even index, low byte at the odd one.
   function automatic logic [2:0] hi_idx(input logic [1:0] pair);
      return {pair, 1'b0};
   endfunction

   function automatic logic [2:0] lo_idx(input logic [1:0] pair);
      return {pair, 1'b1};
   endfunction

endpackage

// File: rtl/regpair_writer_if.sv
// Request handshake, register-file ports and result outputs of the pair write sequencer.
interface regpair_writer_if;

   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [1:0]  req_pair;
   logic [15:0] req_data;
   logic [1:0]  rf_rdwn;
   logic [15:0] rf_rdw;
   logic [2:0]  rf_wrn;
   logic [7:0]  rf_wr;
   logic        rf_we;
   logic        done;
   logic [15:0] result;
   logic        flag_h;
   logic        flag_c;

   // master: control unit plus register file; slave: the sequencer
   modport master (
      output req_valid, req_op, req_pair, req_data, rf_rdw,
      input  req_ready, rf_rdwn, rf_wrn, rf_wr, rf_we, done, result, flag_h, flag_c
   );

   modport slave (
      input  req_valid, req_op, req_pair, req_data, rf_rdw,
      output req_ready, rf_rdwn, rf_wrn, rf_wr, rf_we, done, result, flag_h, flag_c
   );

endinterface

// File: rtl/regpair_writer_alu16.sv
// Combinational 16-bit pair arithmetic: load, increment, decrement, signed 8-bit add with H/C.
module regpair_alu16
   import regpair_writer_pkg::*;
(
   input  logic [1:0]  i_op,
   input  logic [15:0] i_rdw,
   input  logic [15:0] i_data,
   output logic [15:0] o_res,
   output logic        o_h,
   output logic        o_c
);

   logic [8:0] w_byte_sum;
   logic [7:0] w_hi_sum;

   // Low byte add yields both flags; H is recovered as the carry into bit 4.
   assign w_byte_sum = {1'b0, i_rdw[7:0]} + {1'b0, i_data[7:0]};
   assign w_hi_sum   = i_rdw[15:8] + {8{i_data[7]}} + {7'd0, w_byte_sum[8]};

   always_comb begin
      o_res = i_data;
      o_h   = 1'b0;
      o_c   = 1'b0;
      case (i_op)
         OP_LOAD: o_res = i_data;
         OP_INC:  o_res = i_rdw + 16'd1;
         OP_DEC:  o_res = i_rdw - 16'd1;
         OP_ADDS: begin
            o_res = {w_hi_sum, w_byte_sum[7:0]};
            o_h   = i_rdw[4] ^ i_data[4] ^ w_byte_sum[4];
            o_c   = w_byte_sum[8];
         end
         default: o_res = i_data;
      endcase
   end

endmodule

// File: rtl/regpair_writer.sv
// Accepts one pair operation, then writes the result low byte then high byte to the register file.
module regpair_writer
   import regpair_writer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   regpair_writer_if.slave bus
);

   state_e      r_state;
   state_e      w_state_next;
   logic [1:0]  r_pair;
   logic [15:0] r_res;
   logic        r_h;
   logic        r_c;
   logic        w_accept;
   logic [15:0] w_alu_res;
   logic        w_alu_h;
   logic        w_alu_c;

   assign bus.req_ready = (r_state == ST_IDLE) && !rst;
   assign w_accept      = bus.req_valid && bus.req_ready;
   assign bus.rf_rdwn   = (r_state == ST_IDLE) ? bus.req_pair : r_pair;

   regpair_alu16 u_alu (
      .i_op   (bus.req_op),
      .i_rdw  (bus.rf_rdw),
      .i_data (bus.req_data),
      .o_res  (w_alu_res),
      .o_h    (w_alu_h),
      .o_c    (w_alu_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_pair  <= 2'd0;
         r_res   <= 16'd0;
         r_h     <= 1'b0;
         r_c     <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_pair <= bus.req_pair;
            r_res  <= w_alu_res;
            r_h    <= w_alu_h;
            r_c    <= w_alu_c;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      bus.rf_we    = 1'b0;
      bus.rf_wrn   = 3'd0;
      bus.rf_wr    = 8'd0;
      bus.done     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_state_next = ST_WR_LO;
         end
         ST_WR_LO: begin
            w_state_next = ST_WR_HI;
            bus.rf_we    = 1'b1;
            bus.rf_wrn   = lo_idx(r_pair);
            bus.rf_wr    = r_res[7:0];
         end
         ST_WR_HI: begin
            w_state_next = ST_IDLE;
            bus.rf_we    = 1'b1;
            bus.rf_wrn   = hi_idx(r_pair);
            bus.rf_wr    = r_res[15:8];
            bus.done     = 1'b1;
         end
         default: w_state_next = ST_IDLE;
      endcase
      // Reset kills the write in the same cycle so an aborted op never lands its next byte.
      if (rst) begin
         bus.rf_we  = 1'b0;
         bus.rf_wrn = 3'd0;
         bus.rf_wr  = 8'd0;
         bus.done   = 1'b0;
      end
   end

   assign bus.result = r_res;
   assign bus.flag_h = r_h;
   assign bus.flag_c = r_c;

endmodule

// File: tb/tb_regpair_writer.sv
// Scoreboard bench: issued ops push expected byte writes; a monitor pops them as the DUT writes.
module tb_regpair_writer;
   import regpair_writer_pkg::*;

   typedef struct packed {
      logic [1:0]  op;
      logic [1:0]  pair;
      logic [15:0] data;
      logic [15:0] res;
      logic        h;
      logic        c;
   } vec_t;

   typedef struct packed {
      logic [2:0]  wrn;
      logic [7:0]  wr;
      logic        done;
      logic [15:0] result;
      logic        h;
      logic        c;
   } exp_t;

   logic clk;
   logic rst;
   logic preload;
   logic [7:0] rf_mem [0:7];
   exp_t sb_q [$];
   int   n_checks;
   int   n_pass;
   longint last_acc;
   bit   have_last;
   vec_t vecs [0:11];

   regpair_writer_if bus ();

   regpair_writer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register-file model: combinational pair read, byte write on the clock edge.
   assign bus.rf_rdw = {rf_mem[{bus.rf_rdwn, 1'b0}], rf_mem[{bus.rf_rdwn, 1'b1}]};

   always @(posedge clk) begin
      if (preload) begin
         rf_mem[0] <= 8'hFF; rf_mem[1] <= 8'hFF;
         rf_mem[2] <= 8'h00; rf_mem[3] <= 8'h00;
         rf_mem[4] <= 8'h55; rf_mem[5] <= 8'h55;
         rf_mem[6] <= 8'hFF; rf_mem[7] <= 8'hF8;
      end else if (bus.rf_we) begin
         rf_mem[bus.rf_wrn] <= bus.rf_wr;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   always @(negedge clk) begin
      exp_t e;
      #1;
      if (bus.rf_we || bus.done) begin
         if (sb_q.size() == 0) begin
            check("unexpected_write", {16'd0, 1'b1, bus.rf_wrn, bus.rf_wr, 4'd0}, 32'd0);
         end else begin
            e = sb_q.pop_front();
            $display("write idx=%0d data=%h done=%0b", bus.rf_wrn, bus.rf_wr, bus.done);
            check(e.done ? "hi_write" : "lo_write",
                  {20'd0, bus.rf_we, bus.done, bus.rf_wrn, bus.rf_wr},
                  {20'd0, 1'b1, e.done, e.wrn, e.wr});
            if (e.done)
               check("result_flags", {14'd0, bus.result, bus.flag_h, bus.flag_c},
                     {14'd0, e.result, e.h, e.c});
         end
      end
   end

   task automatic issue(input vec_t v, input bit abort_hi);
      int n;
      exp_t e;
      bus.req_op    = v.op;
      bus.req_pair  = v.pair;
      bus.req_data  = v.data;
      bus.req_valid = 1'b1;
      n = 0;
      #1;
      while (!bus.req_ready && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!bus.req_ready) begin
         check("accept_timeout", 32'd0, 32'd1);
      end else begin
         @(posedge clk);
         $display("accept op=%0d pair=%0d data=%h expect=%h h=%0b c=%0b",
                  v.op, v.pair, v.data, v.res, v.h, v.c);
         if (have_last) check("accept_gap", 32'(($time - last_acc) / 10), 32'd3);
         last_acc  = $time;
         have_last = 1'b1;
         e = '{wrn: {v.pair, 1'b1}, wr: v.res[7:0], done: 1'b0, result: v.res, h: v.h, c: v.c};
         sb_q.push_back(e);
         if (!abort_hi) begin
            e.wrn  = {v.pair, 1'b0};
            e.wr   = v.res[15:8];
            e.done = 1'b1;
            sb_q.push_back(e);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      have_last = 1'b0;
      last_acc  = 0;
      preload   = 1'b1;
      rst       = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_op    = 2'd0;
      bus.req_pair  = 2'd0;
      bus.req_data  = 16'd0;

      vecs[0]  = '{OP_LOAD, PAIR_HL, 16'h1234, 16'h1234, 1'b0, 1'b0};
      vecs[1]  = '{OP_INC,  PAIR_BC, 16'h0000, 16'h0000, 1'b0, 1'b0};
      vecs[2]  = '{OP_DEC,  PAIR_DE, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
      vecs[3]  = '{OP_ADDS, PAIR_SP, 16'h0008, 16'h0000, 1'b1, 1'b1};
      vecs[4]  = '{OP_INC,  PAIR_HL, 16'h0000, 16'h1235, 1'b0, 1'b0};
      vecs[5]  = '{OP_LOAD, PAIR_SP, 16'h0005, 16'h0005, 1'b0, 1'b0};
      vecs[6]  = '{OP_ADDS, PAIR_SP, 16'hAAFE, 16'h0003, 1'b1, 1'b1};
      vecs[7]  = '{OP_LOAD, PAIR_BC, 16'h0100, 16'h0100, 1'b0, 1'b0};
      vecs[8]  = '{OP_DEC,  PAIR_BC, 16'h0000, 16'h00FF, 1'b0, 1'b0};
      vecs[9]  = '{OP_ADDS, PAIR_DE, 16'h0001, 16'h0000, 1'b1, 1'b1};
      vecs[10] = '{OP_LOAD, PAIR_DE, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0};
      vecs[11] = '{OP_ADDS, PAIR_HL, 16'h0080, 16'h11B5, 1'b0, 1'b0};

      repeat (3) @(negedge clk);
      #1;
      check("reset_ready", {31'd0, bus.req_ready}, 32'd0);
      check("reset_outputs", {10'd0, bus.rf_we, bus.done, bus.rf_wrn, bus.rf_wr, 8'd0},
            32'd0);
      check("reset_result", {14'd0, bus.result, bus.flag_h, bus.flag_c}, 32'd0);
      preload = 1'b0;
      rst     = 1'b0;
      #1;
      check("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);
      @(negedge clk);

      // Back-to-back: req_valid stays high across all vectors.
      for (int i = 0; i < 12; i++) issue(vecs[i], 1'b0);

      // Abort in WR_HI: BC holds 0x00FF, so only the low byte 0xCD may land.
      have_last = 1'b0;
      issue('{OP_LOAD, PAIR_BC, 16'hABCD, 16'hABCD, 1'b0, 1'b0}, 1'b1);
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_no_hi_write", {30'd0, bus.rf_we, bus.done}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      #1;
      check("abort_state", {13'd0, bus.req_ready, bus.rf_we, bus.done, bus.result},
            32'd0);
      rst = 1'b0;
      #1;
      check("abort_ready_after", {31'd0, bus.req_ready}, 32'd1);
      check("abort_half_pair", {16'd0, rf_mem[0], rf_mem[1]}, 32'h0000_00CD);
      @(negedge clk);

      have_last = 1'b0;
      issue('{OP_INC, PAIR_BC, 16'h0000, 16'h00CE, 1'b0, 1'b0}, 1'b0);
      bus.req_valid = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      check("queue_drained", 32'(sb_q.size()), 32'd0);
      check("final_bc", {16'd0, rf_mem[0], rf_mem[1]}, 32'h0000_00CE);
      check("final_de", {16'd0, rf_mem[2], rf_mem[3]}, 32'h0000_BEEF);
      check("final_hl", {16'd0, rf_mem[4], rf_mem[5]}, 32'h0000_11B5);
      check("final_sp", {16'd0, rf_mem[6], rf_mem[7]}, 32'h0000_0003);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
